// File: rtl/sensor_pkg.sv
// Shared constants and helpers for the floor-pad sensor conditioning stage.
package sensor_pkg;

  localparam int NUM_SENSORS_DEFAULT = 24;
  localparam int INDEX_W             = 5;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [INDEX_W-1:0] lowest_set(input logic [31:0] v);
    lowest_set = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set = INDEX_W'(i);
    end
  endfunction

  function automatic int cnt_width(input int stable_ticks);
    return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/sensor_debounce_bit.sv
// One pad: optional inversion, 2-flop synchronizer and tick-based debounce.
module sensor_debounce_bit
  import sensor_pkg::*;
#(
  parameter int STABLE_TICKS = 8,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic stable,
  output logic rise
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          stable_reg, stable_next;
  logic          sync;

  assign sync = sync_reg[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg   <= '0;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[0], raw ^ ACTIVE_LOW};
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
    end
  end

  always_comb begin
    cnt_next    = cnt_reg;
    stable_next = stable_reg;
    if (sync == stable_reg) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt_reg == CNT_LAST) begin
        stable_next = sync;
        cnt_next    = '0;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  assign stable = stable_reg;
  // High in the cycle whose edge raises stable, so the event lands on the same edge.
  assign rise   = stable_next & ~stable_reg;

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces the pad word and queues press events behind a valid/ready handshake.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int NUM_SENSORS  = NUM_SENSORS_DEFAULT,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        sensor_raw,
  output logic [31:0]        sensor_stable,
  output logic               press_valid,
  output logic [INDEX_W-1:0] press_index,
  input  logic               press_ready,
  output logic               press_overflow,
  input  logic               clear_overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_reg;
  logic          tick;
  logic [31:0]   stable_vec, rise_vec;
  logic [31:0]   pending_reg, pending_next, consume_mask;
  logic          overflow_reg, overflow_next;

  assign tick = (presc_reg == PRESC_LAST);

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_pad
      if (gi < NUM_SENSORS) begin : g_live
        sensor_debounce_bit #(
          .STABLE_TICKS(STABLE_TICKS),
          .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_bit (
          .clock (clock),
          .reset (reset),
          .raw   (sensor_raw[gi]),
          .tick  (tick),
          .stable(stable_vec[gi]),
          .rise  (rise_vec[gi])
        );
      end else begin : g_tied
        logic unused_raw;
        assign unused_raw     = sensor_raw[gi];
        assign stable_vec[gi] = 1'b0;
        assign rise_vec[gi]   = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    consume_mask = '0;
    if (press_valid && press_ready) consume_mask[press_index] = 1'b1;
    // A new rise on the bit being consumed re-arms it rather than overflowing.
    pending_next  = (pending_reg & ~consume_mask) | rise_vec;
    overflow_next = (|(rise_vec & pending_reg & ~consume_mask)) |
                    (overflow_reg & ~clear_overflow);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_reg    <= '0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      presc_reg    <= tick ? '0 : presc_reg + PW'(1);
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
    end
  end

  assign sensor_stable  = stable_vec;
  assign press_valid    = |pending_reg;
  assign press_index    = lowest_set(pending_reg);
  assign press_overflow = overflow_reg;

endmodule
